// File: rtl/vsram_load_ctrl.sv
// rtl/vsram_load_ctrl.sv - fill-side sequencer streaming whole tiles of rows from memory into the vector SRAM
`ifndef NUM_PES
`define NUM_PES 4
`endif

module vsram_load_ctrl #(
  parameter int  NUM_ROWS   = `NUM_PES,
  parameter int  ADDR_W     = 32,
  parameter int  ROW_BYTES  = 64,
  parameter int  TILE_W     = 16,
  parameter type Q_VECTOR_T = logic [127:0],
  localparam int ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              busy,
  output logic              done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  Q_VECTOR_T         mem_rsp_data,
  output logic              vsram_write_enable,
  output Q_VECTOR_T         vsram_write_data,
  input  logic              vsram_ready,
  output logic [ROW_W-1:0]  row_idx,
  output logic [TILE_W-1:0] tile_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_valid_q, req_valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [TILE_W-1:0] tiles_q, tiles_d;
  logic [ROW_W-1:0]  row_idx_q, row_idx_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  Q_VECTOR_T         hold_q, hold_d;

  logic last_row;
  logic last_tile;

  assign last_row  = (row_idx_q == ROW_W'(NUM_ROWS - 1));
  assign last_tile = (tile_idx_q == (tiles_q - TILE_W'(1)));

  // Every output is a flop; next values depend on inputs only through the state transitions.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    req_valid_d = req_valid_q;
    we_d        = we_q;
    cur_addr_d  = cur_addr_q;
    tiles_d     = tiles_q;
    row_idx_d   = row_idx_q;
    tile_idx_d  = tile_idx_q;
    hold_d      = hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          row_idx_d  = '0;
          tile_idx_d = '0;
          if (num_tiles != '0) begin
            cur_addr_d  = base_addr;
            tiles_d     = num_tiles;
            req_valid_d = 1'b1;
            state_d     = S_REQ;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          hold_d  = mem_rsp_data;
          we_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (vsram_ready) begin
          we_d       = 1'b0;
          cur_addr_d = cur_addr_q + ADDR_W'(ROW_BYTES);
          if (last_row) begin
            row_idx_d  = '0;
            tile_idx_d = tile_idx_q + TILE_W'(1);
          end else begin
            row_idx_d = row_idx_q + ROW_W'(1);
          end
          if (last_row && last_tile) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            req_valid_d = 1'b1;
            state_d     = S_REQ;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        req_valid_d = 1'b0;
        we_d        = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      cur_addr_q  <= '0;
      tiles_q     <= '0;
      row_idx_q   <= '0;
      tile_idx_q  <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      we_q        <= we_d;
      cur_addr_q  <= cur_addr_d;
      tiles_q     <= tiles_d;
      row_idx_q   <= row_idx_d;
      tile_idx_q  <= tile_idx_d;
      hold_q      <= hold_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign mem_req_valid      = req_valid_q;
  assign mem_req_addr       = cur_addr_q;
  assign vsram_write_enable = we_q;
  assign vsram_write_data   = hold_q;
  assign row_idx            = row_idx_q;
  assign tile_idx           = tile_idx_q;

endmodule

// File: tb/tb_vsram_load_ctrl.sv
// tb/tb_vsram_load_ctrl.sv - randomized self-checking bench for vsram_load_ctrl against a row-stream model
module tb_vsram_load_ctrl;
  localparam int NR = 4;
  localparam int RB = 64;
  typedef logic [63:0] q_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_tiles = '0;
  logic        busy, done, mem_req_valid, vsram_write_enable;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0, vsram_ready = 1'b0;
  logic [31:0] mem_req_addr;
  q_t          mem_rsp_data = '0, vsram_write_data;
  logic [1:0]  row_idx;
  logic [15:0] tile_idx;

  logic        w_start = 1'b0;
  logic [7:0]  w_base = '0;
  logic [15:0] w_num = '0;
  logic        w_busy, w_done, w_req_valid, w_we;
  logic        w_one = 1'b1;
  logic [7:0]  w_req_addr;
  q_t          w_rsp_data = 64'h5a5a_0000_1234_abcd, w_wdata;
  logic [1:0]  w_row;
  logic [15:0] w_tile;

  always #5 clk = ~clk;

  vsram_load_ctrl #(.NUM_ROWS(NR), .ADDR_W(32), .ROW_BYTES(RB), .TILE_W(16), .Q_VECTOR_T(q_t)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .busy(busy), .done(done), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .vsram_write_enable(vsram_write_enable), .vsram_write_data(vsram_write_data),
    .vsram_ready(vsram_ready), .row_idx(row_idx), .tile_idx(tile_idx));

  vsram_load_ctrl #(.NUM_ROWS(NR), .ADDR_W(8), .ROW_BYTES(RB), .TILE_W(16), .Q_VECTOR_T(q_t)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .base_addr(w_base), .num_tiles(w_num),
    .busy(w_busy), .done(w_done), .mem_req_valid(w_req_valid), .mem_req_ready(w_one),
    .mem_req_addr(w_req_addr), .mem_rsp_valid(w_one), .mem_rsp_data(w_rsp_data),
    .vsram_write_enable(w_we), .vsram_write_data(w_wdata),
    .vsram_ready(w_one), .row_idx(w_row), .tile_idx(w_tile));

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] req_q[$];
  q_t          wr_q[$];
  int          wr_row[$];
  int          wr_tile[$];
  logic [7:0]  w_q[$];
  logic [31:0] exp_addr[$];
  q_t          exp_data[$];
  int          done_cnt = 0;
  bit          valid_seen = 0;

  int  req_stall = 0, rsp_delay = 0, sram_stall_at = -1, sram_stall_len = 0;
  bit  sram_rand = 0, stale_inj = 0;
  logic [31:0] salt = 32'h1357_9bdf;

  bit          pend = 0, hs_prev = 0, req_seen = 0, wr_seen = 0;
  int          pend_wait = 0, req_cnt = 0, wr_stall = 0;
  logic [31:0] pend_addr = '0, hs_addr = '0, req_hold = '0;
  q_t          wr_hold = '0;

  function automatic q_t data_of(input logic [31:0] a);
    return {a ^ salt, a + salt};
  endfunction

  // Memory holds data_of(addr) at every row address; SRAM logs each accepted write.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (mem_req_valid) valid_seen = 1;
      if (!rst_n) begin
        pend = 0; hs_prev = 0; req_seen = 0; wr_seen = 0; wr_stall = 0;
        mem_req_ready = 0; vsram_ready = 0; mem_rsp_valid = 0;
      end else begin
        mem_rsp_valid = stale_inj;
        if (hs_prev) begin
          pend = 1; pend_wait = rsp_delay; pend_addr = hs_addr;
        end
        if (pend) begin
          if (pend_wait == 0) begin
            mem_rsp_valid = 1; mem_rsp_data = data_of(pend_addr); pend = 0;
          end else pend_wait--;
        end
        if (mem_req_valid) begin
          n_vec++;
          if ((req_seen && mem_req_addr !== req_hold) || pend) begin
            n_err++;
            $display("FAIL req_protocol: addr %h held %h outstanding %0d", mem_req_addr, req_hold, pend);
          end
          if (!req_seen) begin req_seen = 1; req_hold = mem_req_addr; req_cnt = req_stall; end
          mem_req_ready = (req_cnt == 0);
          if (req_cnt > 0) req_cnt--;
          hs_prev = mem_req_ready; hs_addr = mem_req_addr;
          if (mem_req_ready) req_q.push_back(mem_req_addr);
        end else begin
          req_seen = 0; hs_prev = 0; mem_req_ready = 1'($urandom_range(0, 1));
        end
        if (vsram_write_enable) begin
          if (!wr_seen) begin
            wr_seen = 1; wr_hold = vsram_write_data;
            wr_stall = (wr_q.size() == sram_stall_at) ? sram_stall_len : (sram_rand ? $urandom_range(0, 2) : 0);
          end else begin
            n_vec++;
            if (vsram_write_data !== wr_hold) begin
              n_err++;
              $display("FAIL write_stable: data %h held %h", vsram_write_data, wr_hold);
            end
          end
          vsram_ready = (wr_stall == 0);
          if (wr_stall > 0) wr_stall--;
          if (vsram_ready) begin
            wr_q.push_back(vsram_write_data); wr_row.push_back(int'(row_idx)); wr_tile.push_back(int'(tile_idx));
          end
        end else begin
          wr_seen = 0; vsram_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (w_req_valid) w_q.push_back(w_req_addr);
    end
  end

  task automatic clear_log();
    req_q.delete(); wr_q.delete(); wr_row.delete(); wr_tile.delete();
    done_cnt = 0; valid_seen = 0; salt = $urandom;
  endtask

  task automatic build_exp(input logic [31:0] base, input int nt);
    exp_addr.delete(); exp_data.delete();
    for (int i = 0; i < nt * NR; i++) begin
      exp_addr.push_back(base + 32'(i * RB));
      exp_data.push_back(data_of(base + 32'(i * RB)));
    end
  endtask

  task automatic run_cmd(input logic [31:0] base, input logic [15:0] nt, input int ign_at, output int lat);
    start = 1; base_addr = base; num_tiles = nt;
    @(posedge clk); #1;
    start = 0; lat = 1;
    while (!done && lat < 3000) begin
      if (lat == ign_at) begin start = 1; num_tiles = 16'd3; base_addr = 32'h9000; end
      else start = 0;
      @(posedge clk); #1;
      lat++;
    end
    start = 0;
    n_vec++;
    if (!done) begin n_err++; $display("FAIL done_timeout: no done after %0d cycles", lat); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, mem_req_valid, vsram_write_enable} !== 4'b0 || mem_req_addr !== '0 ||
        vsram_write_data !== '0 || row_idx !== '0 || tile_idx !== '0) begin
      n_err++;
      $display("FAIL reset_values: ctl %b addr %h data %h row %0d tile %0d expected all zero",
               {busy, done, mem_req_valid, vsram_write_enable}, mem_req_addr, vsram_write_data, row_idx, tile_idx);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_tile();
    int lat;
    clear_log(); req_stall = 0; rsp_delay = 0; sram_rand = 0; sram_stall_at = -1;
    build_exp(32'h1000, 1);
    run_cmd(32'h1000, 16'd1, -1, lat);
    n_vec++;
    if (lat !== 13) begin n_err++; $display("FAIL single_latency: %0d cycles expected 13", lat); end
    n_vec++;
    if (wr_q.size() != exp_data.size() || req_q.size() != exp_addr.size()) begin
      n_err++; $display("FAIL single_count: writes %0d reqs %0d expected %0d", wr_q.size(), req_q.size(), exp_data.size());
    end else foreach (wr_q[i]) begin
      n_vec++;
      if (req_q[i] !== exp_addr[i] || wr_q[i] !== exp_data[i] || wr_row[i] != i % NR || wr_tile[i] != i / NR) begin
        n_err++; $display("FAIL single_row%0d: addr %h data %h expected %h %h", i, req_q[i], wr_q[i], exp_addr[i], exp_data[i]);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: busy %b expected 0", busy); end
  endtask

  task automatic test_two_tiles_backpressure();
    int lat;
    clear_log(); sram_stall_at = 4; sram_stall_len = 5;
    build_exp(32'h4000, 2);
    run_cmd(32'h4000, 16'd2, -1, lat);
    sram_stall_at = -1;
    n_vec++;
    if (lat !== 3 * NR * 2 + 1 + 5) begin n_err++; $display("FAIL two_latency: %0d cycles expected %0d", lat, 3 * NR * 2 + 6); end
    n_vec++;
    if (wr_q.size() != exp_data.size() || req_q.size() != exp_addr.size()) begin
      n_err++; $display("FAIL two_count: writes %0d reqs %0d expected %0d", wr_q.size(), req_q.size(), exp_data.size());
    end else foreach (wr_q[i]) begin
      n_vec++;
      if (req_q[i] !== exp_addr[i] || wr_q[i] !== exp_data[i] || wr_row[i] != i % NR || wr_tile[i] != i / NR) begin
        n_err++; $display("FAIL two_row%0d: addr %h data %h tile %0d expected %h %h %0d", i, req_q[i], wr_q[i], wr_tile[i], exp_addr[i], exp_data[i], i / NR);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (done_cnt != 1) begin n_err++; $display("FAIL two_done_count: %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_mem_stalls();
    int lat;
    clear_log(); req_stall = 3; rsp_delay = 4;
    build_exp(32'h0002_0000, 1);
    run_cmd(32'h0002_0000, 16'd1, -1, lat);
    n_vec++;
    if (lat !== NR * (3 + 3 + 4) + 1) begin n_err++; $display("FAIL mem_latency: %0d cycles expected %0d", lat, NR * 10 + 1); end
    n_vec++;
    if (wr_q.size() != exp_data.size() || req_q.size() != exp_addr.size()) begin
      n_err++; $display("FAIL mem_count: writes %0d reqs %0d expected %0d", wr_q.size(), req_q.size(), exp_data.size());
    end else foreach (wr_q[i]) begin
      n_vec++;
      if (req_q[i] !== exp_addr[i] || wr_q[i] !== exp_data[i]) begin
        n_err++; $display("FAIL mem_row%0d: addr %h data %h expected %h %h", i, req_q[i], wr_q[i], exp_addr[i], exp_data[i]);
      end
    end
    req_stall = 0; rsp_delay = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_and_busy_start();
    int lat;
    clear_log();
    run_cmd(32'h2000, 16'd0, -1, lat);
    n_vec++;
    if (lat !== 1 || busy !== 1'b1) begin n_err++; $display("FAIL zero_done: latency %0d busy %b expected 1 1", lat, busy); end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || valid_seen || req_q.size() != 0) begin
      n_err++; $display("FAIL zero_traffic: busy %b req_seen %0d reqs %0d expected 0 0 0", busy, valid_seen, req_q.size());
    end
    clear_log();
    build_exp(32'h3000, 1);
    run_cmd(32'h3000, 16'd1, 5, lat);
    repeat (12) @(posedge clk);
    #1;
    n_vec++;
    if (lat !== 13 || done_cnt != 1 || busy !== 1'b0 || req_q.size() != exp_addr.size()) begin
      n_err++; $display("FAIL busy_start: latency %0d done %0d busy %b reqs %0d expected 13 1 0 %0d", lat, done_cnt, busy, req_q.size(), exp_addr.size());
    end else foreach (req_q[i]) begin
      n_vec++;
      if (req_q[i] !== exp_addr[i] || wr_q[i] !== exp_data[i]) begin
        n_err++; $display("FAIL busy_start_row%0d: addr %h expected %h", i, req_q[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    clear_log();
    run_cmd(32'h5000, 16'd1, -1, lat);
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: busy %b expected 0", busy); end
    req_q.delete(); wr_q.delete(); wr_row.delete(); wr_tile.delete();
    build_exp(32'h6000, 1);
    run_cmd(32'h6000, 16'd1, -1, lat);
    n_vec++;
    if (lat !== 13 || req_q.size() != exp_addr.size()) begin
      n_err++; $display("FAIL b2b_second: latency %0d reqs %0d expected 13 %0d", lat, req_q.size(), exp_addr.size());
    end else foreach (req_q[i]) begin
      n_vec++;
      if (req_q[i] !== exp_addr[i] || wr_q[i] !== exp_data[i]) begin
        n_err++; $display("FAIL b2b_row%0d: addr %h data %h expected %h %h", i, req_q[i], wr_q[i], exp_addr[i], exp_data[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addr_wrap();
    int cyc = 0;
    logic [7:0] ea;
    w_q.delete();
    w_base = 8'hC0; w_num = 16'd1; w_start = 1;
    @(posedge clk); #1;
    w_start = 0;
    while (!w_done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (!w_done || w_q.size() != NR) begin
      n_err++; $display("FAIL wrap_count: done %b reqs %0d expected 1 %0d", w_done, w_q.size(), NR);
    end else foreach (w_q[i]) begin
      ea = 8'hC0 + 8'(i * RB);
      n_vec++;
      if (w_q[i] !== ea) begin n_err++; $display("FAIL wrap_addr%0d: %h expected %h", i, w_q[i], ea); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    int lat;
    clear_log(); sram_stall_at = 2; sram_stall_len = 50;
    start = 1; base_addr = 32'h7000; num_tiles = 16'd1;
    @(posedge clk); #1;
    start = 0;
    while (!(vsram_write_enable && wr_q.size() == 2) && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (!(vsram_write_enable && wr_q.size() == 2)) begin n_err++; $display("FAIL rst_reach_row2: writes %0d expected 2", wr_q.size()); end
    #3 rst_n = 0;
    #1;
    n_vec++;
    if ({busy, done, mem_req_valid, vsram_write_enable} !== 4'b0 || mem_req_addr !== '0 ||
        vsram_write_data !== '0 || row_idx !== '0 || tile_idx !== '0) begin
      n_err++; $display("FAIL async_reset: ctl %b addr %h row %0d expected zero", {busy, done, mem_req_valid, vsram_write_enable}, mem_req_addr, row_idx);
    end
    sram_stall_at = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    stale_inj = 1;
    repeat (2) @(posedge clk);
    #1 stale_inj = 0;
    n_vec++;
    if (busy !== 1'b0 || vsram_write_enable !== 1'b0 || wr_q.size() != 2) begin
      n_err++; $display("FAIL stale_rsp: busy %b we %b writes %0d expected 0 0 2", busy, vsram_write_enable, wr_q.size());
    end
    @(posedge clk); #1;
    clear_log();
    build_exp(32'h7000, 1);
    run_cmd(32'h7000, 16'd1, -1, lat);
    n_vec++;
    if (lat !== 13 || wr_q.size() != exp_data.size()) begin
      n_err++; $display("FAIL rst_fresh: latency %0d writes %0d expected 13 %0d", lat, wr_q.size(), exp_data.size());
    end else foreach (wr_q[i]) begin
      n_vec++;
      if (req_q[i] !== exp_addr[i] || wr_q[i] !== exp_data[i]) begin
        n_err++; $display("FAIL rst_fresh_row%0d: addr %h data %h expected %h %h", i, req_q[i], wr_q[i], exp_addr[i], exp_data[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, nt;
    logic [31:0] base;
    for (int k = 0; k < 6; k++) begin
      clear_log();
      req_stall = $urandom_range(0, 2); rsp_delay = $urandom_range(0, 2); sram_rand = 1;
      nt = $urandom_range(1, 3);
      base = $urandom & 32'hFFFF_FFC0;
      build_exp(base, nt);
      run_cmd(base, 16'(nt), -1, lat);
      @(posedge clk); #1;
      n_vec++;
      if (done_cnt != 1 || wr_q.size() != exp_data.size() || req_q.size() != exp_addr.size()) begin
        n_err++; $display("FAIL rand%0d_count: done %0d writes %0d reqs %0d expected 1 %0d", k, done_cnt, wr_q.size(), req_q.size(), exp_data.size());
      end else foreach (wr_q[i]) begin
        n_vec++;
        if (req_q[i] !== exp_addr[i] || wr_q[i] !== exp_data[i] || wr_row[i] != i % NR || wr_tile[i] != i / NR) begin
          n_err++; $display("FAIL rand%0d_row%0d: addr %h data %h expected %h %h", k, i, req_q[i], wr_q[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    req_stall = 0; rsp_delay = 0; sram_rand = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_tile();
    test_two_tiles_backpressure();
    test_mem_stalls();
    test_zero_and_busy_start();
    test_back_to_back();
    test_addr_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vsram_load_ctrl.md
# vsram_load_ctrl

Fill-side sequencer for the double-buffered vector SRAM that feeds the PE array. On a start command it walks a contiguous region of external memory one vector row at a time and writes each row into the SRAM fill bank, honouring the SRAM's ready back-pressure. It stops after a programmed number of full tiles of `NUM_ROWS` rows. It sits between the memory controller's read port and the vector SRAM write port.

## Interface
- `NUM_ROWS`, default `` `NUM_PES ``: rows per SRAM bank (one tile); power of two ≥ 2.
- `ADDR_W`, default 32: memory byte-address width.
- `ROW_BYTES`, default 64: byte stride between consecutive rows.
- `TILE_W`, default 16: width of the tile count.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle command pulse; sampled only in IDLE.
- `base_addr` in `ADDR_W`: first row address; latched on accepted `start`.
- `num_tiles` in `TILE_W`: tiles to load; latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the command completes.
- `mem_req_valid` out 1: read request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out `ADDR_W`: row address of the request.
- `mem_rsp_valid` in 1: read data valid, exactly one per accepted request.
- `mem_rsp_data` in `Q_VECTOR_T`: returned row.
- `vsram_write_enable` out 1: to SRAM `write_enable`.
- `vsram_write_data` out `Q_VECTOR_T`: to SRAM `write_data`.
- `vsram_ready` in 1: from SRAM `sram_ready`; a write takes effect when `vsram_write_enable && vsram_ready`.
- `row_idx` out `$clog2(NUM_ROWS)`: row within the current tile.
- `tile_idx` out `TILE_W`: current tile.

## Operation
- FSM states: IDLE, REQ, WAIT, WRITE, DONE.
- **IDLE:** on `start` with `num_tiles != 0`:
  - latch `cur_addr = base_addr` and `tiles = num_tiles`;
  - clear `row_idx` and `tile_idx`;
  - go to REQ.
- **IDLE, zero-tile start:** `start` with `num_tiles == 0` goes to DONE with no memory traffic.
- **REQ:** `mem_req_valid = 1`, `mem_req_addr = cur_addr`; hold both stable until `mem_req_ready`, then go to WAIT.
- **WAIT:** on `mem_rsp_valid`, capture `mem_rsp_data` into the hold register and go to WRITE.
- **WRITE:**
  - `vsram_write_enable = 1`, `vsram_write_data = hold`, both held stable while `vsram_ready = 0`.
  - On `vsram_ready`: `cur_addr += ROW_BYTES` (mod 2^`ADDR_W`) and `row_idx += 1`.
  - If `row_idx == NUM_ROWS-1`: `row_idx` wraps to 0 and `tile_idx += 1`.
  - If that row was the last row of tile `tiles-1`, go to DONE; otherwise go to REQ.
- **DONE:** `done = 1` for exactly one cycle, then go to IDLE.
- `start` is ignored in every state except IDLE.
- `mem_rsp_valid` outside WAIT is ignored, including a stale response arriving after reset.
- Only one request is outstanding at a time; no request is issued while a row is held.
- Row order within a tile is strictly ascending address. SRAM bank ping-pong is driven by the SRAM's own row count, and the controller always writes whole tiles to keep it aligned.

## Timing
- Reset values:
  - `busy`, `done`, `mem_req_valid`, `vsram_write_enable` = 0;
  - `mem_req_addr`, `vsram_write_data`, `row_idx`, `tile_idx` = 0;
  - state = IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Command accept: `start` at edge N, `mem_req_valid` high from cycle N+1.
- Best-case row throughput is 3 cycles (REQ, WAIT, WRITE), with zero-wait memory and a ready SRAM.
- Total best-case latency from `start` to `done`: 3·`NUM_ROWS`·`num_tiles` + 1 cycles.
- Zero-tile command: `done` pulses in cycle N+1 and `busy` is high for that cycle only.
- `busy` falls in the cycle after `done`. A `start` in that same cycle is accepted.
- Back-pressure:
  - `mem_req_ready` low stalls in REQ indefinitely;
  - `vsram_ready` low stalls in WRITE indefinitely;
  - no data loss and no duplicate writes.
- Reset mid-operation clears the FSM immediately. Rows already written into the SRAM are not undone; the SRAM is reset alongside.

## Test plan
Bench parameters: `NUM_ROWS`=4, `ROW_BYTES`=64.
- **Single tile:** base 0x1000, 1 tile, zero-wait memory, SRAM always ready.
  - Requests go to 0x1000, 0x1040, 0x1080, 0x10C0.
  - 4 SRAM writes land in order.
  - `done` pulses 13 cycles after `start`.
- **Two tiles with SRAM back-pressure:** 2 tiles; `vsram_ready` low for 5 cycles at row 4.
  - 8 writes, data held stable through the stall.
  - `tile_idx` steps 0→1 after the 4th write.
  - `done` pulses once, 5 cycles later than the unstalled case.
- **Memory stalls:** `mem_req_ready` low 3 cycles and response delayed 4 cycles on every row.
  - Address is held during the stall.
  - Exactly one request is outstanding at any time.
  - All rows arrive correct.
- **Zero tiles and busy-start:** `num_tiles`=0 gives `done` at N+1 with no `mem_req_valid`. A `start` pulsed while busy is ignored: the original command completes with its own count.
- **Address wrap:** `ADDR_W`=8, base 0xC0, 1 tile gives addresses 0xC0, 0x00, 0x40, 0x80.
- **Async reset mid-command:** `rst_n` low during WRITE of row 2.
  - Outputs go to reset values immediately.
  - A stale `mem_rsp_valid` after reset is ignored.
  - A fresh command then completes normally.
